// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants for the iterative RV32M multiply/divide
// sequencer.
//   - funct3 encodings of the supported M-extension ops.
//   - ALU selector codes. The sequencer drives only ADD and SUB.
//   - Sequencer state encoding.
//   - Default datapath width.
package muldiv_pkg;

  localparam int DWIDTH_DEF = 32;

  localparam logic [2:0] OP_MUL  = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEG_A,
    ST_NEG_B,
    ST_ITER,
    ST_POST,
    ST_DONE
  } state_t;

  // DIV and REM work on magnitudes and need sign fix-up around the loop.
  function automatic logic op_is_signed_div(input logic [2:0] op);
    return op[2] & ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide controller. It steps an
// external ALU (ADD/SUB only) through shift-add multiplication or restoring
// division. The loop handles one bit per cycle.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   start_i            request; accepted when start_i && ready_o
//   op_i               funct3 (MUL/DIV/DIVU/REM/REMU)
//   a_i, b_i           rs1/rs2 operands, latched on accept
//   kill_i             abort any in-flight operation
//   ready_o            high only in IDLE
//   done_o             one-cycle pulse when result_o is updated
//   result_o           result; held until the next completed operation
//   alu_a_o, alu_b_o   ALU operands
//   alu_sel_o          ALU selector (ALU_ADD / ALU_SUB)
//   alu_out_i          ALU result, combinational in the same cycle
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DWIDTH-1:0] a_i,
  input  logic [DWIDTH-1:0] b_i,
  input  logic              kill_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [DWIDTH-1:0] result_o,
  output logic [DWIDTH-1:0] alu_a_o,
  output logic [DWIDTH-1:0] alu_b_o,
  output logic [3:0]        alu_sel_o,
  input  logic [DWIDTH-1:0] alu_out_i
);

  localparam int              CW       = $clog2(DWIDTH) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWIDTH - 1);
  localparam logic [DWIDTH-1:0] ALL_ONES = '1;
  localparam logic [DWIDTH-1:0] MIN_NEG  = {1'b1, {(DWIDTH-1){1'b0}}};

  state_t            state;
  logic [2:0]        op_q;
  logic [DWIDTH-1:0] opa_q;   // multiplier / dividend-then-quotient
  logic [DWIDTH-1:0] opb_q;   // multiplicand / divisor
  logic [DWIDTH-1:0] acc_q;   // product accumulator / partial remainder
  logic [CW-1:0]     cnt_q;
  logic              a_neg_q;
  logic              b_neg_q;

  // Accept-time short cuts: these ops finish without touching the ALU.
  logic              special;
  logic [DWIDTH-1:0] special_res;

  always_comb begin
    special     = 1'b0;
    special_res = '0;
    case (op_i)
      OP_MUL: special = 1'b0;
      OP_DIV, OP_REM: begin
        if (b_i == '0) begin
          special     = 1'b1;
          special_res = (op_i == OP_REM) ? a_i : ALL_ONES;
        end else if (a_i == MIN_NEG && b_i == ALL_ONES) begin
          special     = 1'b1;
          special_res = (op_i == OP_REM) ? '0 : MIN_NEG;
        end
      end
      OP_DIVU, OP_REMU: begin
        if (b_i == '0) begin
          special     = 1'b1;
          special_res = (op_i == OP_REMU) ? a_i : ALL_ONES;
        end
      end
      default: special = 1'b1;  // unsupported funct3 returns 0
    endcase
  end

  logic              is_mul;
  logic              is_sdiv;
  logic [DWIDTH-1:0] rs;
  logic              rs_ge;
  logic [DWIDTH-1:0] acc_nxt;
  logic [DWIDTH-1:0] opa_nxt;
  logic [DWIDTH-1:0] post_x;
  logic              post_neg;
  logic [DWIDTH-1:0] rs0;
  logic              rs0_ge;

  assign is_mul   = (op_q == OP_MUL);
  assign is_sdiv  = op_is_signed_div(op_q);
  assign rs       = {acc_q[DWIDTH-2:0], opa_q[DWIDTH-1]};
  assign rs_ge    = (rs >= opb_q);
  assign post_x   = (op_q == OP_DIV) ? opa_q : acc_q;
  assign post_neg = (op_q == OP_DIV) ? (a_neg_q ^ b_neg_q) : a_neg_q;

  // The first restoring step for signed ops is folded into NEG_B. At that
  // point the partial remainder is zero, so the shifted value is only
  // |a|[MSB]. The step therefore needs a compare against |b| (arriving
  // on alu_out_i), but no subtract: when the compare succeeds, both values
  // are 1 and the new remainder is 0. This keeps signed latency at
  // DWIDTH+3.
  assign rs0    = {{(DWIDTH-1){1'b0}}, opa_q[DWIDTH-1]};
  assign rs0_ge = (rs0 >= alu_out_i);

  always_comb begin
    if (is_mul) begin
      acc_nxt = alu_out_i;
      opa_nxt = opa_q >> 1;
    end else begin
      acc_nxt = rs_ge ? alu_out_i : rs;
      opa_nxt = {opa_q[DWIDTH-2:0], rs_ge};
    end
  end

  // ALU operand steering: negate is sub(0, x), pass-through is add(x, 0).
  always_comb begin
    alu_a_o   = '0;
    alu_b_o   = '0;
    alu_sel_o = ALU_ADD;
    case (state)
      ST_NEG_A: begin
        if (opa_q[DWIDTH-1]) begin
          alu_b_o   = opa_q;
          alu_sel_o = ALU_SUB;
        end else begin
          alu_a_o = opa_q;
        end
      end
      ST_NEG_B: begin
        if (opb_q[DWIDTH-1]) begin
          alu_b_o   = opb_q;
          alu_sel_o = ALU_SUB;
        end else begin
          alu_a_o = opb_q;
        end
      end
      ST_ITER: begin
        if (is_mul) begin
          alu_a_o = acc_q;
          alu_b_o = opb_q & {DWIDTH{opa_q[0]}};
        end else begin
          alu_a_o   = rs;
          alu_b_o   = opb_q;
          alu_sel_o = ALU_SUB;
        end
      end
      ST_POST: begin
        if (post_neg) begin
          alu_b_o   = post_x;
          alu_sel_o = ALU_SUB;
        end else begin
          alu_a_o = post_x;
        end
      end
      default: alu_sel_o = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      ready_o  <= 1'b1;
      done_o   <= 1'b0;
      result_o <= '0;
    end else if (kill_i && state != ST_IDLE) begin
      // A kill in DONE still lets the already-raised done_o pulse show.
      state   <= ST_IDLE;
      ready_o <= 1'b1;
      done_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            op_q    <= op_i;
            opa_q   <= a_i;
            opb_q   <= b_i;
            acc_q   <= '0;
            cnt_q   <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            ready_o <= 1'b0;
            done_o  <= 1'b0;
            if (special) begin
              result_o <= special_res;
              done_o   <= 1'b1;
              state    <= ST_DONE;
            end else if (op_is_signed_div(op_i)) begin
              state <= ST_NEG_A;
            end else begin
              state <= ST_ITER;
            end
          end
        end
        ST_NEG_A: begin
          opa_q   <= alu_out_i;
          a_neg_q <= opa_q[DWIDTH-1];
          state   <= ST_NEG_B;
        end
        ST_NEG_B: begin
          opb_q   <= alu_out_i;
          b_neg_q <= opb_q[DWIDTH-1];
          acc_q   <= rs0_ge ? '0 : rs0;
          opa_q   <= {opa_q[DWIDTH-2:0], rs0_ge};
          cnt_q   <= CW'(1);
          state   <= ST_ITER;
        end
        ST_ITER: begin
          acc_q <= acc_nxt;
          opa_q <= opa_nxt;
          cnt_q <= cnt_q + CW'(1);
          if (is_mul) opb_q <= opb_q << 1;
          if (cnt_q == CNT_LAST) begin
            if (is_sdiv) begin
              state <= ST_POST;
            end else begin
              result_o <= (is_mul || op_q[1]) ? acc_nxt : opa_nxt;
              done_o   <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end
        ST_POST: begin
          result_o <= alu_out_i;
          done_o   <= 1'b1;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          done_o  <= 1'b0;
          ready_o <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: self-checking bench for muldiv_sequencer. Contains a
// behavioural ALU, directed cases, and randomized ops compared against an
// arithmetic reference model.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_i;
  logic [2:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         kill_i;
  logic         ready_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic [W-1:0] alu_a_o;
  logic [W-1:0] alu_b_o;
  logic [3:0]   alu_sel_o;
  logic [W-1:0] alu_out_i;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] last_res = '0;
  logic [3:0]   sel_all  = '0;

  always #5 clk = ~clk;

  assign alu_out_i = (alu_sel_o == ALU_SUB) ? alu_a_o - alu_b_o :
                     (alu_sel_o == ALU_ADD) ? alu_a_o + alu_b_o : 32'hDEAD_BEEF;

  muldiv_sequencer #(.DWIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_i),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .kill_i    (kill_i),
    .ready_o   (ready_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .alu_a_o   (alu_a_o),
    .alu_b_o   (alu_b_o),
    .alu_sel_o (alu_sel_o),
    .alu_out_i (alu_out_i)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      3'b000: return a * b;
      3'b101: return (b == 0) ? '1 : a / b;
      3'b111: return (b == 0) ? a : a % b;
      3'b100: begin
        if (b == 0) return '1;
        if (a == MIN_NEG && b == '1) return MIN_NEG;
        return sa / sb;
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == '1) return '0;
        return sa % sb;
      end
      default: return '0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    bit signed_div;
    signed_div = (op == 3'b100) || (op == 3'b110);
    if (op != 3'b000 && !op[2]) return 1;
    if (op[2] && b == 0) return 1;
    if (signed_div && a == MIN_NEG && b == '1) return 1;
    return signed_div ? W + 3 : W + 1;
  endfunction

  // Issues one op and checks latency, result and the return to ready.
  // poke_cyc > 0 raises start_i for one busy cycle. poke_done raises it in
  // the done cycle. Neither start may be taken.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit kill_at_start, input int poke_cyc,
                        input bit poke_done, output logic [3:0] sel_seen);
    int           cyc;
    int           lat;
    logic [W-1:0] exp;
    exp      = ref_result(op, a, b);
    lat      = ref_latency(op, a, b);
    sel_seen = '0;
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b; kill_i = kill_at_start;
    @(negedge clk);
    start_i = 1'b0; kill_i = 1'b0; a_i = $urandom; b_i = $urandom;
    check({tag, "/busy"}, 32'(ready_o), 32'd0);
    cyc = 1;
    while (!done_o && cyc < 100) begin
      sel_seen |= alu_sel_o;
      start_i = (cyc == poke_cyc);
      op_i    = OP_MUL;
      @(negedge clk);
      cyc++;
    end
    check({tag, "/latency"}, 32'(cyc), 32'(lat));
    check({tag, "/result"}, result_o, exp);
    start_i = poke_done;
    op_i    = OP_MUL;
    @(negedge clk);
    start_i = 1'b0;
    check({tag, "/ready_after"}, {30'd0, ready_o, done_o}, 32'd2);
    last_res = exp;
    sel_all |= sel_seen;
  endtask

  initial begin
    logic [3:0]   sel;
    logic [2:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit           seen_done;

    reset = 1'b1; start_i = 1'b0; kill_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk);
    check("rst/ready", 32'(ready_o), 32'd1);
    check("rst/done", 32'(done_o), 32'd0);
    check("rst/result", result_o, 32'd0);
    check("rst/alu", {alu_a_o[15:0], alu_b_o[11:0], alu_sel_o}, 32'd0);
    reset = 1'b0;

    run_op("mul7x6", OP_MUL, 32'd7, 32'd6, 1'b0, 0, 1'b0, sel);
    check("mul7x6/sel_add", 32'(sel), 32'd0);
    run_op("div-7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 1'b0, sel);
    run_op("rem-7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 1'b0, sel);
    run_op("divu_by0", OP_DIVU, 32'h1234, 32'd0, 1'b0, 0, 1'b0, sel);
    run_op("remu_by0", OP_REMU, 32'd5, 32'd0, 1'b0, 0, 1'b0, sel);
    run_op("div_ovf", OP_DIV, MIN_NEG, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, sel);
    run_op("rem_ovf", OP_REM, MIN_NEG, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, sel);
    run_op("div_min_by1", OP_DIV, MIN_NEG, 32'd1, 1'b0, 0, 1'b0, sel);
    run_op("rem_neg_neg", OP_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, 0, 1'b0, sel);
    run_op("unsupported", 3'b010, 32'd9, 32'd3, 1'b0, 0, 1'b0, sel);
    run_op("busy_start", OP_REMU, 32'd1000, 32'd13, 1'b0, 5, 1'b1, sel);
    run_op("kill_with_start", OP_DIVU, 32'd1000, 32'd7, 1'b1, 0, 1'b0, sel);

    // Kill mid-divide: no done pulse, previous result retained.
    @(negedge clk);
    start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    seen_done = 1'b0;
    for (int c = 1; c < 10; c++) begin
      seen_done |= done_o;
      @(negedge clk);
    end
    kill_i = 1'b1;
    seen_done |= done_o;
    @(negedge clk);
    kill_i = 1'b0;
    seen_done |= done_o;
    check("kill/no_done", 32'(seen_done), 32'd0);
    check("kill/ready", 32'(ready_o), 32'd1);
    check("kill/result_kept", result_o, last_res);
    run_op("mul3x3", OP_MUL, 32'd3, 32'd3, 1'b0, 0, 1'b0, sel);

    // Kill in DONE still shows the done pulse.
    @(negedge clk);
    start_i = 1'b1; op_i = OP_DIVU; a_i = 32'h55; b_i = 32'd0;
    @(negedge clk);
    start_i = 1'b0; kill_i = 1'b1;
    check("kill_done/done", 32'(done_o), 32'd1);
    check("kill_done/result", result_o, 32'hFFFF_FFFF);
    @(negedge clk);
    kill_i = 1'b0;
    check("kill_done/ready", {30'd0, ready_o, done_o}, 32'd2);

    // Reset mid-operation.
    @(negedge clk);
    start_i = 1'b1; op_i = OP_REMU; a_i = $urandom; b_i = $urandom | 32'd1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst/ready", 32'(ready_o), 32'd1);
    check("midrst/done", 32'(done_o), 32'd0);
    check("midrst/result", result_o, 32'd0);
    check("midrst/alu_a", alu_a_o, 32'd0);
    check("midrst/alu_b", alu_b_o, 32'd0);
    check("midrst/alu_sel", 32'(alu_sel_o), 32'd0);
    reset = 1'b0;
    last_res = '0;

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: rop = OP_MUL;
        1: rop = OP_DIV;
        2: rop = OP_DIVU;
        3: rop = OP_REM;
        4: rop = OP_REMU;
        default: rop = 3'($urandom_range(0, 7));
      endcase
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'($urandom_range(0, 15));
        1: rb = '0;
        2: begin ra = MIN_NEG; rb = ($urandom_range(0, 1) == 0) ? '1 : 32'd1; end
        3: rb = -32'($urandom_range(1, 9));
        default: ra = ra;
      endcase
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 1'b0, 0, 1'b0, sel);
    end

    check("alu_sel_range", 32'(sel_all & 4'b1110), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide controller for the integer pipeline.
- Sequences a dedicated instance of the team's ALU over DWIDTH iterations, using only its ADD and SUB operations.
- Sits beside the single-cycle core. The core stalls on ready_o low and picks up result_o on done_o.
- Performs MUL, DIV, DIVU, REM and REMU with RISC-V divide-by-zero and overflow semantics.

Parameters:
DWIDTH, 32, operand/result width; also the iteration count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start_i  input  1  request; accepted only when start_i && ready_o.
- op_i  input  3  funct3: 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU; 001/010/011 unsupported.
- a_i  input  DWIDTH  rs1 operand, sampled on accept.
- b_i  input  DWIDTH  rs2 operand, sampled on accept.
- kill_i  input  1  abort the in-flight operation (pipeline flush).
- ready_o  output  1  high only in IDLE.
- done_o  output  1  one-cycle pulse when result_o becomes valid.
- result_o  output  DWIDTH  result; held until the next accepted start.
- alu_a_o  output  DWIDTH  ALU in_a.
- alu_b_o  output  DWIDTH  ALU in_b.
- alu_sel_o  output  4  ALU_Sel; only 0000 (add) and 0001 (sub) are ever driven.
- alu_out_i  input  DWIDTH  ALU result (combinational, same cycle).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. Reset values: state=IDLE, ready_o=1, done_o=0, result_o=0, alu_a_o=0, alu_b_o=0, alu_sel_o=0000. All internal registers are cleared.
- States: IDLE, NEG_A, NEG_B, ITER, POST, DONE.
- IDLE: ALU outputs are 0/0/ADD. On accept (cycle 0), the block latches op, a, b and clears done_o. Next state:
  - Special case (divide by zero, DIV/REM overflow, unsupported op): DONE. done_o rises in cycle 1.
  - DIV/REM: NEG_A.
  - Otherwise: ITER.
- Special cases:
  - Divisor 0: quotient = all ones, remainder = a.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - Unsupported op: result 0.
- NEG_A (signed ops only): ALU sub(0, a) if a[MSB] is set, else add(a, 0); the result replaces a. The block also records a_neg. Next state: NEG_B.
- NEG_B: same treatment for b, recording b_neg. Next state: ITER.
- ITER: DWIDTH cycles, counted by a log2(DWIDTH)+1-bit counter.
  - MUL: ALU add(acc, mcand & {DWIDTH{mplier[0]}}); acc <= alu_out_i; mcand <<= 1; mplier >>= 1. Low word only; sign-agnostic, so no NEG/POST states.
  - DIVU/REMU/DIV/REM (restoring division): rs = {rem[DWIDTH-2:0], quo[MSB]}; quo <<= 1; ALU sub(rs, divisor).
    - If rs >= divisor (internal unsigned compare): rem <= alu_out_i and quo[0] <= 1.
    - Otherwise: rem <= rs.
- POST (signed ops only): negate with ALU sub(0, x), or pass through with add(x, 0).
  - DIV: negate when a_neg ^ b_neg.
  - REM: negate when a_neg.
- DONE: result_o is loaded; done_o = 1 for exactly this cycle; next state IDLE.
  - Quotient for DIV/DIVU, remainder for REM/REMU, acc for MUL.
- Latency, from the accept cycle to the done_o cycle:
  - MUL/DIVU/REMU: DWIDTH+1 (33).
  - DIV/REM: DWIDTH+3 (35).
  - Special cases: 1.
- Handshake rules:
  - start_i while ready_o=0 is ignored.
  - A start in the same cycle as DONE is not accepted; ready_o rises the cycle after done_o.
- kill_i:
  - In any non-IDLE state: next state IDLE; no done_o; result_o unchanged.
  - In IDLE: has no effect.
  - kill_i together with start_i in IDLE: start is accepted.
  - kill_i in DONE: done_o still pulses this cycle.
- Reset mid-operation: returns immediately to reset values; no done_o.
- All arithmetic is modulo 2^DWIDTH; the counter must not wrap.

Decomposition:
- Package muldiv_pkg holds:
  - funct3 op constants (OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU).
  - ALU selector constants ALU_ADD=4'b0000 and ALU_SUB=4'b0001, shared with the core decoder.
  - State encoding.
  - DWIDTH default.
- No sub-module. The ALU instance lives in the parent wrapper (muldiv_unit) and is connected through the alu_* ports.

Test Plan:
- MUL a=7, b=6 -> done_o at cycle 33, result_o=42; ALU sel is 0000 throughout; ready_o=1 at cycle 34.
- DIV a=-7 (0xFFFFFFF9), b=2 -> done_o at cycle 35, result_o=0xFFFFFFFD (-3). Then REM with the same operands -> 0xFFFFFFFF (-1).
- DIVU a=0x1234, b=0 -> result 0xFFFFFFFF at cycle 1. REMU a=5, b=0 -> result 5 at cycle 1.
- DIV 0x80000000/0xFFFFFFFF -> result 0x80000000 at cycle 1. REM with the same operands -> 0.
- DIVU 100/7, kill_i at cycle 10 -> no done_o, ready_o=1 at cycle 11, result_o keeps its prior value. A new start MUL 3*3 -> 9.
- reset at cycle 20 of a REMU -> all outputs at reset values next cycle. A start_i while busy -> ignored, and the original operation's result is unaffected.
